// File: rtl/hyperbus_resp_pkg.sv
// Shared types and constants for the HyperBus responder: FSM states,
// command/address field positions, register map and register defaults.
package hyperbus_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CA    = 3'd1,
    ST_LAT   = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  // Command/address bit positions within the 48-bit CA word
  localparam int unsigned CA_RW_BIT = 47;  // 1 = read
  localparam int unsigned CA_AS_BIT = 46;  // 1 = register space
  localparam int unsigned CA_BT_BIT = 45;  // burst type, ignored
  localparam int unsigned CA_ROW_HI = 44;
  localparam int unsigned CA_ROW_LO = 16;
  localparam int unsigned CA_COL_HI = 2;

  // Register space word addresses
  localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG_CR0_ADDR = 32'h0100_0000;

  localparam logic [15:0] CR0_DEFAULT = 16'h8F1F;
  localparam logic [15:0] ID0_VALUE   = 16'h0C81;

  // Word address carried by a CA word: upper row/column bits plus the
  // low column bits; the reserved CA[15:3] field is skipped.
  function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
    return {ca[CA_ROW_HI:CA_ROW_LO], ca[CA_COL_HI:0]};
  endfunction

endpackage

// File: rtl/hyperbus_resp_mem.sv
// Single-port 16-bit word array with per-byte write enables and a
// registered read port.
module hyperbus_resp_mem #(
  parameter int unsigned MemWords = 1024,
  parameter int unsigned AddrW    = $clog2(MemWords)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AddrW-1:0] addr,
  input  logic             we,
  input  logic [1:0]       be,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata
);

  logic [15:0] mem_r [MemWords];

  // Byte-enabled write; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we) begin
      if (be[1]) mem_r[addr][15:8] <= wdata[15:8];
      if (be[0]) mem_r[addr][7:0]  <= wdata[7:0];
    end
  end

  // Registered read of the currently addressed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 16'h0000;
    end else begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/hyperbus_resp.sv
// HyperBus responder: synchronizes the pads onto clk_i, turns every CK
// transition into a one-byte step, and runs the CA / latency / data FSM
// against a word array and the CR0/ID0 register space.
module hyperbus_resp
  import hyperbus_resp_pkg::*;
#(
  parameter int unsigned MemWords      = 1024,
  parameter int unsigned LatencyCycles = 6,
  parameter logic [15:0] Cr0Default    = CR0_DEFAULT,
  parameter logic [15:0] Id0Value      = ID0_VALUE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       hyper_reset_ni,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  input  logic       hyper_rwds_i,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o
);

  localparam int unsigned AddrW     = $clog2(MemWords);
  // Fixed 2x latency, two edge events per CK cycle
  localparam logic [7:0]  LAT_EDGES = 8'(4 * LatencyCycles);
  // Synchronizer layout {reset_n, cs_n, ck, rwds, dq}; CS idles high
  localparam logic [11:0] SYNC_RST  = 12'h400;

  logic [11:0] sync1_r, sync2_r;
  logic        ck_prev_r;
  logic        reset_n_s, cs_n_s, ck_s, rwds_s, edge_s, abort_s;
  logic [7:0]  dq_s;

  state_e      state_r;
  logic [39:0] ca_r;
  logic [47:0] ca_next_s;
  logic        ca_unused_s;
  logic [2:0]  byte_cnt_r;
  logic [7:0]  lat_cnt_r;
  logic [31:0] addr_r;
  logic        is_read_r, is_reg_r, lo_next_r;
  logic [7:0]  hi_byte_r;
  logic        hi_mask_r;
  logic [15:0] cr0_r;
  logic [7:0]  dq_r;
  logic        dq_oe_r, rwds_r, rwds_oe_r;

  logic [15:0] mem_rdata_s, reg_rdata_s, rd_word_s;
  logic        mem_we_s;

  assign reset_n_s   = sync2_r[11];
  assign cs_n_s      = sync2_r[10];
  assign ck_s        = sync2_r[9];
  assign rwds_s      = sync2_r[8];
  assign dq_s        = sync2_r[7:0];
  assign edge_s      = ck_s ^ ck_prev_r;
  assign abort_s     = cs_n_s | ~reset_n_s;
  assign ca_next_s   = {ca_r, dq_s};
  assign ca_unused_s = ^{ca_next_s[CA_BT_BIT], ca_next_s[15:3]};

  assign hyper_dq_o      = dq_r;
  assign hyper_dq_oe_o   = dq_oe_r;
  assign hyper_rwds_o    = rwds_r;
  assign hyper_rwds_oe_o = rwds_oe_r;

  // Two-flop synchronizer on every pad input plus previous CK sample
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_r   <= SYNC_RST;
      sync2_r   <= SYNC_RST;
      ck_prev_r <= 1'b0;
    end else begin
      sync1_r   <= {hyper_reset_ni, hyper_cs_ni, hyper_ck_i, hyper_rwds_i, hyper_dq_i};
      sync2_r   <= sync1_r;
      ck_prev_r <= ck_s;
    end
  end

  // Read word source: register space decode or the array's read port
  always_comb begin
    reg_rdata_s = 16'h0000;
    rd_word_s   = 16'h0000;
    if (addr_r == REG_ID0_ADDR) begin
      reg_rdata_s = Id0Value;
    end else if (addr_r == REG_CR0_ADDR) begin
      reg_rdata_s = cr0_r;
    end else begin
      reg_rdata_s = 16'h0000;
    end
    if (is_reg_r) begin
      rd_word_s = reg_rdata_s;
    end else begin
      rd_word_s = mem_rdata_s;
    end
  end

  // Array write strobe: the upper byte is held until its low byte arrives,
  // so an aborted half-word never reaches the array
  always_comb begin
    mem_we_s = 1'b0;
    if (edge_s && !abort_s && (state_r == ST_WRITE) && lo_next_r && !is_reg_r) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  hyperbus_resp_mem #(
    .MemWords (MemWords),
    .AddrW    (AddrW)
  ) u_mem (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .addr  (addr_r[AddrW-1:0]),
    .we    (mem_we_s),
    .be    ({~hi_mask_r, ~rwds_s}),
    .wdata ({hi_byte_r, dq_s}),
    .rdata (mem_rdata_s)
  );

  // Transaction FSM with registered DQ/RWDS drivers and CR0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      ca_r       <= 40'h00_0000_0000;
      byte_cnt_r <= 3'd0;
      lat_cnt_r  <= 8'd0;
      addr_r     <= 32'h0000_0000;
      is_read_r  <= 1'b0;
      is_reg_r   <= 1'b0;
      lo_next_r  <= 1'b0;
      hi_byte_r  <= 8'h00;
      hi_mask_r  <= 1'b0;
      cr0_r      <= Cr0Default;
      dq_r       <= 8'h00;
      dq_oe_r    <= 1'b0;
      rwds_r     <= 1'b0;
      rwds_oe_r  <= 1'b0;
    end else if (abort_s) begin
      // CS high or device reset takes priority over any edge this cycle
      state_r   <= ST_IDLE;
      dq_r      <= 8'h00;
      dq_oe_r   <= 1'b0;
      rwds_r    <= 1'b0;
      rwds_oe_r <= 1'b0;
      if (!reset_n_s) cr0_r <= Cr0Default;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r    <= ST_CA;
          byte_cnt_r <= 3'd0;
          lo_next_r  <= 1'b0;
          rwds_r     <= 1'b1;  // announces fixed 2x latency
          rwds_oe_r  <= 1'b1;
          dq_oe_r    <= 1'b0;
        end
        ST_CA: begin
          if (edge_s) begin
            ca_r       <= ca_next_s[39:0];
            byte_cnt_r <= byte_cnt_r + 3'd1;
            if (byte_cnt_r == 3'd5) begin
              addr_r    <= ca_word_addr(ca_next_s);
              is_read_r <= ca_next_s[CA_RW_BIT];
              is_reg_r  <= ca_next_s[CA_AS_BIT];
              rwds_r    <= 1'b0;
              rwds_oe_r <= 1'b0;
              if (!ca_next_s[CA_RW_BIT] && ca_next_s[CA_AS_BIT]) begin
                state_r <= ST_WRITE;  // register writes skip latency
              end else begin
                state_r   <= ST_LAT;
                lat_cnt_r <= LAT_EDGES;
              end
            end
          end
        end
        ST_LAT: begin
          if (edge_s) begin
            lat_cnt_r <= lat_cnt_r - 8'd1;
            if (is_read_r && (lat_cnt_r == 8'd2)) begin
              rwds_r    <= 1'b0;  // read preamble over the last latency interval
              rwds_oe_r <= 1'b1;
            end
            if (lat_cnt_r <= 8'd1) begin
              state_r <= is_read_r ? ST_READ : ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (edge_s) begin
            lo_next_r <= ~lo_next_r;
            if (!lo_next_r) begin
              hi_byte_r <= dq_s;
              hi_mask_r <= rwds_s;
            end else begin
              if (is_reg_r && (addr_r == REG_CR0_ADDR)) cr0_r <= {hi_byte_r, dq_s};
              addr_r <= addr_r + 32'd1;
            end
          end
        end
        ST_READ: begin
          if (edge_s) begin
            dq_r      <= lo_next_r ? rd_word_s[7:0] : rd_word_s[15:8];
            dq_oe_r   <= 1'b1;
            rwds_r    <= ~rwds_r;
            rwds_oe_r <= 1'b1;
            lo_next_r <= ~lo_next_r;
            if (lo_next_r) addr_r <= addr_r + 32'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperbus_resp.sv
// Self-checking bench for hyperbus_resp: acts as the controller PHY,
// drives CK at one edge per 4 clk_i cycles and scoreboards read bytes.
module tb_hyperbus_resp;

  localparam int LAT = 6;
  localparam logic [31:0] CR0_A = 32'h0100_0000;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       hyper_reset_ni = 1'b1;
  logic       hyper_cs_ni = 1'b1;
  logic       hyper_ck_i = 1'b0;
  logic [7:0] hyper_dq_i = 8'h00;
  logic       hyper_rwds_i = 1'b0;
  logic [7:0] hyper_dq_o;
  logic       hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        regsp;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[8];

  hyperbus_resp #(.MemWords(1024), .LatencyCycles(LAT)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .hyper_reset_ni  (hyper_reset_ni),
    .hyper_cs_ni     (hyper_cs_ni),
    .hyper_ck_i      (hyper_ck_i),
    .hyper_dq_i      (hyper_dq_i),
    .hyper_dq_o      (hyper_dq_o),
    .hyper_dq_oe_o   (hyper_dq_oe_o),
    .hyper_rwds_i    (hyper_rwds_i),
    .hyper_rwds_o    (hyper_rwds_o),
    .hyper_rwds_oe_o (hyper_rwds_oe_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic ck_edge(input logic [7:0] d, input logic rw);
    @(negedge clk_i);
    hyper_dq_i   = d;
    hyper_rwds_i = rw;
    hyper_ck_i   = ~hyper_ck_i;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic cs_low();
    @(negedge clk_i);
    hyper_cs_ni = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic cs_high();
    @(negedge clk_i);
    hyper_cs_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_dq_oe", hyper_dq_oe_o, 1'b0);
    check("abort_rwds_oe", hyper_rwds_oe_o, 1'b0);
    repeat (4) @(posedge clk_i);
  endtask

  task automatic send_ca(input logic rd, input logic regsp, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, regsp, 1'b1, a[31:3], 13'h0000, a[2:0]};
    cs_low();
    check("ca_rwds_oe", hyper_rwds_oe_o, 1'b1);
    check("ca_rwds", hyper_rwds_o, 1'b1);
    for (int i = 0; i < 6; i++) ck_edge(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic lat(input logic rd);
    for (int i = 0; i < 4*LAT; i++) begin
      ck_edge(8'h00, 1'b0);
      if (i == 4*LAT-2) begin
        check("lat_dq_oe", hyper_dq_oe_o, 1'b0);
        if (rd) begin
          check("preamble_rwds_oe", hyper_rwds_oe_o, 1'b1);
          check("preamble_rwds", hyper_rwds_o, 1'b0);
        end else begin
          check("wlat_rwds_oe", hyper_rwds_oe_o, 1'b0);
        end
      end
      if (i == 4*LAT-1) check("lat_end_dq_oe", hyper_dq_oe_o, 1'b0);
    end
  endtask

  task automatic rd_bytes(input int n);
    logic [7:0] e;
    for (int k = 0; k < n; k++) begin
      ck_edge(8'h00, 1'b0);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check("rd_dq", hyper_dq_o, e);
      check("rd_dq_oe", hyper_dq_oe_o, 1'b1);
      check("rd_rwds_oe", hyper_rwds_oe_o, 1'b1);
      check("rd_rwds_toggle", hyper_rwds_o, (k % 2 == 0));
    end
  endtask

  task automatic do_write(input logic regsp, input logic [31:0] a, input int n,
                          input logic [15:0] w0, input logic [15:0] w1, input logic [1:0] m);
    send_ca(1'b0, regsp, a);
    if (!regsp) lat(1'b0);
    ck_edge(w0[15:8], m[1]);
    ck_edge(w0[7:0], m[0]);
    if (n > 1) begin
      ck_edge(w1[15:8], 1'b0);
      ck_edge(w1[7:0], 1'b0);
    end
    cs_high();
  endtask

  task automatic do_read(input logic regsp, input logic [31:0] a, input int n);
    send_ca(1'b1, regsp, a);
    lat(1'b1);
    rd_bytes(2*n);
    cs_high();
  endtask

  initial begin
    // regsp, addr, write data, mask {hi,lo}, expected readback
    vecs[0] = '{1'b0, 32'h0000_0005, 16'hFFFF, 2'b00, 16'hFFFF};
    vecs[1] = '{1'b0, 32'h0000_0005, 16'h1234, 2'b01, 16'h12FF};
    vecs[2] = '{1'b1, CR0_A,         16'h8F17, 2'b11, 16'h8F17};
    vecs[3] = '{1'b1, 32'h0000_0000, 16'h1111, 2'b00, 16'h0C81};
    vecs[4] = '{1'b1, 32'h0000_0002, 16'hAAAA, 2'b00, 16'h0000};
    vecs[5] = '{1'b0, 32'h0000_040A, 16'h5A5A, 2'b00, 16'h5A5A};
    vecs[6] = '{1'b0, 32'h0000_000A, 16'h0000, 2'b11, 16'h5A5A};
    vecs[7] = '{1'b0, 32'h0000_0011, 16'hC0DE, 2'b00, 16'hC0DE};

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_dq", hyper_dq_o, 8'h00);
    check("rst_dq_oe", hyper_dq_oe_o, 1'b0);
    check("rst_rwds", hyper_rwds_o, 1'b0);
    check("rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);

    for (int v = 0; v < 8; v++) begin
      do_write(vecs[v].regsp, vecs[v].addr, 1, vecs[v].wdata, 16'h0000, vecs[v].mask);
      expect_word(vecs[v].exp);
      do_read(vecs[v].regsp, vecs[v].addr, 1);
    end

    // 2-word burst read across a freshly written word
    do_write(1'b0, 32'h10, 1, 16'hBEEF, 16'h0000, 2'b00);
    expect_word(16'hBEEF);
    expect_word(16'hC0DE);
    do_read(1'b0, 32'h10, 2);

    // burst write wrapping from the last word to word 0
    do_write(1'b0, 32'h3FF, 2, 16'h1111, 16'h2222, 2'b00);
    expect_word(16'h1111);
    expect_word(16'h2222);
    do_read(1'b0, 32'h3FF, 2);
    expect_word(16'h2222);
    do_read(1'b0, 32'h0, 1);

    // CS raised after the third byte of a 4-byte write
    do_write(1'b0, 32'h20, 2, 16'h0000, 16'h0000, 2'b00);
    send_ca(1'b0, 1'b0, 32'h20);
    lat(1'b0);
    ck_edge(8'hAB, 1'b0);
    ck_edge(8'hCD, 1'b0);
    ck_edge(8'hEF, 1'b0);
    cs_high();
    expect_word(16'hABCD);
    expect_word(16'h0000);
    do_read(1'b0, 32'h20, 2);

    // device reset restores CR0 and keeps the array
    do_write(1'b1, CR0_A, 1, 16'h4321, 16'h0000, 2'b00);
    @(negedge clk_i);
    hyper_reset_ni = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    hyper_reset_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    expect_word(16'h8F1F);
    do_read(1'b1, CR0_A, 1);
    expect_word(16'hBEEF);
    do_read(1'b0, 32'h10, 1);

    // system reset in the middle of a CR0 read (CR0 rewritten first)
    do_write(1'b1, CR0_A, 1, 16'h8F17, 16'h0000, 2'b00);
    exp_q.push_back(8'h8F);
    send_ca(1'b1, 1'b1, CR0_A);
    lat(1'b1);
    rd_bytes(1);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrd_rst_dq_oe", hyper_dq_oe_o, 1'b0);
    check("midrd_rst_rwds_oe", hyper_rwds_oe_o, 1'b0);
    check("midrd_rst_dq", hyper_dq_o, 8'h00);
    hyper_cs_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    expect_word(16'h8F1F);
    do_read(1'b1, CR0_A, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
